wb_rr_arbiter: RTL

Round-robin Wishbone classic arbiter that shares one slave port (e.g. a `wb_ram` instance) between `NM` bus masters such as the SCR1 core and a future DMA engine. The arbiter registers a grant, routes the granted master's request to the slave, and routes the slave's ack back to that master only. An optional watchdog aborts stalled cycles with an error pulse.

---
 rtl/wb_rr_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone classic arbiter, NM masters to one slave; watchdog abort via WB_ARB_TIMEOUT_EN
module wb_rr_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [NM-1:0]        wbm_cyc_i,
    input  logic [NM-1:0]        wbm_stb_i,
    input  logic [NM-1:0]        wbm_we_i,
    input  logic [NM*AW-1:0]     wbm_adr_i,
    input  logic [NM*DW-1:0]     wbm_dat_i,
    input  logic [NM*DW/8-1:0]   wbm_sel_i,
    output logic [DW-1:0]        wbm_dat_o,
    output logic [NM-1:0]        wbm_ack_o,
    output logic [NM-1:0]        wbm_err_o,
    output logic                 wbs_cyc_o,
    output logic                 wbs_stb_o,
    output logic                 wbs_we_o,
    output logic [AW-1:0]        wbs_adr_o,
    output logic [DW-1:0]        wbs_dat_o,
    output logic [DW/8-1:0]      wbs_sel_o,
    input  logic [DW-1:0]        wbs_dat_i,
    input  logic                 wbs_ack_i,
    output logic [NM-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NM);

    if (NM < 2 || NM > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_cfg_check
        $error("wb_rr_arbiter: unsupported NM or TIMEOUT");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

    state_t          state, state_d;
    logic [NM-1:0]   grant_d;
    logic [IW-1:0]   last, last_d;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            found;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0]      stall_cnt;
    logic            timeout_hit;
`endif

    // Search upward from the previous winner so every requester is reached within NM grants.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand   = last;
        for (int k = 1; k <= NM; k++) begin
            cand = IW'((int'(last) + k) % NM);
            if (!found && wbm_cyc_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state;
        grant_d = grant_o;
        last_d  = last;
        case (state)
            IDLE: begin
                if (|wbm_cyc_i) begin
                    state_d = BUSY;
                    last_d  = winner;
                    grant_d = NM'(1) << winner;
                end
            end
            BUSY: begin
                if (!wbm_cyc_i[last]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!wbm_cyc_i[last]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state   <= IDLE;
            grant_o <= '0;
            last    <= IW'(NM - 1);
        end else begin
            state   <= state_d;
            grant_o <= grant_d;
            last    <= last_d;
        end
    end

    // While a grant is held, `last` is the granted index.
    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbm_ack_o = '0;
        if (state != IDLE) begin
            wbs_we_o  = wbm_we_i[last];
            wbs_adr_o = wbm_adr_i[int'(last)*AW +: AW];
            wbs_dat_o = wbm_dat_i[int'(last)*DW +: DW];
            wbs_sel_o = wbm_sel_i[int'(last)*SW +: SW];
            if (state == BUSY) begin
                wbs_cyc_o       = wbm_cyc_i[last];
                wbs_stb_o       = wbm_stb_i[last];
                wbm_ack_o[last] = wbs_ack_i;
            end
        end
    end

    assign wbm_dat_o = wbs_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    assign timeout_hit = (state == BUSY) && wbm_cyc_i[last] && (stall_cnt == 8'(TIMEOUT));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i || state != BUSY || state_d != state) begin
            stall_cnt <= '0;
        end else if (wbs_stb_o && !wbs_ack_i) begin
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
            stall_cnt <= '0;
        end
    end

    always_comb begin
        wbm_err_o       = '0;
        wbm_err_o[last] = timeout_hit;
    end
`else
    assign wbm_err_o = '0;
`endif

endmodule
